// File: rtl/imem_fetch_unit.sv
// Instruction fetch stage: owns the PC, drives the synchronous instruction
// memory, tracks the single in-flight read and buffers returned bytes in a
// 2-entry FIFO that feeds decode over a valid/ready handshake.
module imem_fetch_unit #(
   parameter logic [7:0] RESET_PC = 8'h00
) (
   input  logic       clk,
   input  logic       reset,
   output logic [7:0] imem_addr,
   input  logic [7:0] imem_data,
   input  logic       redirect_valid,
   input  logic [7:0] redirect_pc,
   output logic       inst_valid,
   output logic [7:0] inst,
   output logic [7:0] inst_pc,
   input  logic       inst_ready
);

   // Fetch state
   logic [7:0] pc;
   logic       inflight;
   logic [7:0] inflight_pc;

   // Return queue state
   logic [7:0] q_inst [2];
   logic [7:0] q_pc   [2];
   logic       rd_ptr;
   logic       wr_ptr;
   logic [1:0] count;

   // Handshake / issue decisions
   logic       pop;
   logic       push;
   logic       issue;
   logic [2:0] occupancy;

   // Next-state of the queue and of the registered head
   logic [1:0] count_nxt;
   logic       rd_ptr_nxt;
   logic       wr_ptr_nxt;
   logic [7:0] head_inst_nxt;
   logic [7:0] head_pc_nxt;

   assign imem_addr = pc;

   // inst_valid mirrors count != 0, so a pop always finds count >= 1.
   assign pop  = inst_valid && inst_ready;

   // A redirect discards the byte returning this cycle.
   assign push = inflight && !redirect_valid;

   // Entries that will still occupy the queue after this cycle, counting the
   // in-flight byte; issuing only when this is <= 1 reserves a slot for
   // every byte that returns.
   assign occupancy = {1'b0, count} + {2'b00, inflight} - {2'b00, pop};
   assign issue     = !reset && !redirect_valid && (occupancy <= 3'd1);

   // ---- stage boundary: issue -> memory (pc / inflight registers) ----

   // Program counter and in-flight tracking; reset beats redirect beats issue.
   always_ff @(posedge clk) begin
      if (reset) begin
         pc       <= RESET_PC;
         inflight <= 1'b0;
      end else if (redirect_valid) begin
         pc       <= redirect_pc;
         inflight <= 1'b0;
      end else begin
         inflight <= issue;
         if (issue) begin
            pc <= pc + 8'd1;
         end
      end
   end

   // Remember which address the outstanding memory read belongs to.
   always_ff @(posedge clk) begin
      if (issue) begin
         inflight_pc <= pc;
      end
   end

   // ---- stage boundary: memory -> queue (return path) ----

   // Queue pointer/count update and the value the head register will show.
   always_comb begin
      count_nxt  = count;
      rd_ptr_nxt = rd_ptr;
      wr_ptr_nxt = wr_ptr;
      if (redirect_valid) begin
         count_nxt  = 2'd0;
         rd_ptr_nxt = 1'b0;
         wr_ptr_nxt = 1'b0;
      end else begin
         if (pop) begin
            rd_ptr_nxt = ~rd_ptr;
         end
         if (push) begin
            wr_ptr_nxt = ~wr_ptr;
         end
         if (push && !pop) begin
            count_nxt = count + 2'd1;
         end else if (pop && !push) begin
            count_nxt = count - 2'd1;
         end
      end
      // The new head is the byte being written now only when the write slot
      // is the slot the head pointer moves to (empty queue, or pop+push on a
      // single entry); otherwise it is already stored.
      if (push && (wr_ptr == rd_ptr_nxt)) begin
         head_inst_nxt = imem_data;
         head_pc_nxt   = inflight_pc;
      end else begin
         head_inst_nxt = q_inst[rd_ptr_nxt];
         head_pc_nxt   = q_pc[rd_ptr_nxt];
      end
   end

   // Queue control registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         count  <= 2'd0;
         rd_ptr <= 1'b0;
         wr_ptr <= 1'b0;
      end else begin
         count  <= count_nxt;
         rd_ptr <= rd_ptr_nxt;
         wr_ptr <= wr_ptr_nxt;
      end
   end

   // Queue storage: capture the returning byte with the PC it came from.
   always_ff @(posedge clk) begin
      if (push && !reset) begin
         q_inst[wr_ptr] <= imem_data;
         q_pc[wr_ptr]   <= inflight_pc;
      end
   end

   // ---- stage boundary: queue -> decode (registered head outputs) ----

   // Decode-facing outputs come straight from flops; the head is held when
   // the queue drains so inst/inst_pc never change while not valid-and-new.
   always_ff @(posedge clk) begin
      if (reset) begin
         inst_valid <= 1'b0;
         inst       <= 8'h00;
         inst_pc    <= 8'h00;
      end else begin
         inst_valid <= (count_nxt != 2'd0);
         if (count_nxt != 2'd0) begin
            inst    <= head_inst_nxt;
            inst_pc <= head_pc_nxt;
         end
      end
   end

endmodule
